touch_key_ctrl: RTL and testbench
=================================

TOUCH_KEY_CTRL -- requirements
Module: touch_key_ctrl

Interface
REQ-001 Parameter NUM_KEYS, default 13, number of note channels (1..32).
REQ-002 Parameter NUM_FUNC, fixed 3 (bit0 down, bit1 up, bit2 mode), number of function channels.
REQ-003 Parameter DEB_SAMPLES, default 3, consecutive disagreeing frames required to flip a debounced channel (1..15).
REQ-004 Parameter NUM_MODES, default 2, number of operating modes (2..4).
REQ-005 Parameter PRIO_RECENT, default 0; 0 selects lowest-index priority, 1 selects most-recent-press priority.
REQ-006 clk_in  input  1  system clock.
REQ-007 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-008 sensor_in  input  NUM_KEYS+3  raw touch bitmap; bits [NUM_KEYS-1:0] are notes, [NUM_KEYS+2:NUM_KEYS] are function keys.
REQ-009 sample_valid  input  1  one-cycle strobe marking a new sensor_in frame.
REQ-010 tone_idx  output  TW=$clog2(NUM_KEYS+1)  1-based winning note index, 0 = none.
REQ-011 tone_en  output  1  high when tone_idx != 0.
REQ-012 key_state  output  NUM_KEYS  debounced note bitmap.
REQ-013 func_pulse  output  3  one-cycle pulse per function-key debounced press.
REQ-014 mode  output  2  current mode, 0..NUM_MODES-1.
REQ-015 transpose  output  3  signed octave offset, range -3..+3.

Function
REQ-016 Each of the NUM_KEYS+3 channels SHALL keep a debounced bit and a 4-bit counter, updated only at edges where sample_valid=1.
REQ-017 Raw equals debounced: counter SHALL clear to 0.
REQ-018 Raw differs from debounced: counter SHALL increment; when the incremented value equals DEB_SAMPLES, the debounced bit SHALL toggle and the counter SHALL clear, on that same edge.
REQ-019 sample_valid=0: all debounced bits and counters SHALL hold.
REQ-020 key_state SHALL equal the debounced note bits directly, with no added latency.
REQ-021 tone_idx, tone_en, func_pulse, mode and transpose SHALL be registered and update one cycle after the edge that changed the debounced state (E+1).
REQ-022 With PRIO_RECENT=0, tone_idx SHALL be 1 + the lowest set index of key_state, or 0 when none is set.
REQ-023 With PRIO_RECENT=1, a last_key register SHALL load the lowest-index newly-pressed note on any note rising edge.
REQ-024 With PRIO_RECENT=1, tone_idx SHALL be last_key+1 while that key is held.
REQ-025 With PRIO_RECENT=1, if last_key is released, tone_idx SHALL fall back to the lowest-index held note and last_key SHALL load it; with no note held, tone_idx SHALL be 0.
REQ-026 func_pulse[i] SHALL be high for exactly one cycle per debounced 0->1 transition of function channel i.
REQ-027 Releases and held keys SHALL generate no func_pulse.
REQ-028 A mode pulse SHALL advance mode by 1, wrapping from NUM_MODES-1 to 0.
REQ-029 In mode 0, an up pulse SHALL increment transpose, saturating at +3, and a down pulse SHALL decrement it, saturating at -3.
REQ-030 In mode 0, up and down pulses in the same cycle SHALL leave transpose unchanged.
REQ-031 In modes other than 0, transpose SHALL hold; up/down SHALL still appear on func_pulse for downstream use (song next/prev).
REQ-032 Mode, up and down pulses in the same cycle SHALL all be emitted; transpose SHALL be evaluated using the pre-change mode.
REQ-033 Mode changes SHALL NOT clear transpose or note state.

Reset
REQ-034 While rst_n_in=0, all debounced bits, counters, last_key, tone_idx, tone_en, key_state, func_pulse, mode and transpose SHALL be 0, with immediate effect.
REQ-035 Reset asserted mid-debounce SHALL discard partial counts; after release, a held key SHALL require a full DEB_SAMPLES frames to register.

Verification (NUM_KEYS=13, DEB_SAMPLES=3)
REQ-036 Note bit3 raw=1 for 3 strobes -> key_state=0x0008 at 3rd strobe edge; tone_idx=4, tone_en=1 one cycle later.
REQ-037 Bit3 raw pattern 1,1,0,1,1 over 5 strobes -> key_state stays 0 (counter cleared by the glitch); tone_en=0 throughout.
REQ-038 PRIO_RECENT=1: press bit5, then bit2 -> tone_idx 6 then 3; release bit2 -> tone_idx=6. Same sequence with PRIO_RECENT=0 -> 6, 3, 6.
REQ-039 Up key (sensor bit14) pressed 4 times in mode 0 -> transpose 1,2,3,3; mode key pressed -> mode=1; up pressed -> transpose stays 3 and func_pulse=3'b010 for one cycle.
REQ-040 Mode key pressed NUM_MODES times -> mode returns to 0; holding the mode key for 20 strobes -> exactly one pulse.
REQ-041 rst_n_in pulsed low after 2 of 3 strobes with key held -> all outputs 0 immediately; key registers only after 3 further strobes.

Source files
------------

// File: rtl/touch_key_ctrl.sv
// Touch keyboard front end: per-channel debounce, note priority selection,
// function-key edge pulses, mode cycling and saturating octave transpose.
module touch_key_ctrl #(
  parameter int NUM_KEYS    = 13,
  parameter int NUM_FUNC    = 3,
  parameter int DEB_SAMPLES = 3,
  parameter int NUM_MODES   = 2,
  parameter int PRIO_RECENT = 0,
  localparam int TW  = $clog2(NUM_KEYS + 1),
  localparam int NCH = NUM_KEYS + NUM_FUNC
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [NCH-1:0]      sensor_in,
  input  logic                sample_valid,
  output logic [TW-1:0]       tone_idx,
  output logic                tone_en,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_FUNC-1:0] func_pulse,
  output logic [1:0]          mode,
  output logic [2:0]          transpose
);

  localparam logic [3:0] DEB_LIM = 4'(DEB_SAMPLES);

  logic [NCH-1:0]      deb_q, deb_d, deb_prev_q;
  logic [3:0]          cnt_q [NCH];
  logic [3:0]          cnt_d [NCH];
  logic [TW-1:0]       last_key_q, last_key_d;
  logic [TW-1:0]       tone_q, tone_d;
  logic                tone_en_q;
  logic [NUM_FUNC-1:0] func_q;
  logic [1:0]          mode_q, mode_d;
  logic signed [2:0]   tr_q, tr_d;

  logic [NCH-1:0]      rise;
  logic [NUM_KEYS-1:0] notes, note_rise;
  logic [NUM_FUNC-1:0] func_rise;
  logic                last_held;

  // 1-based index of the lowest set bit, 0 when the vector is empty
  function automatic logic [TW-1:0] lowest_tone(input logic [NUM_KEYS-1:0] v);
    logic [TW-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) r = TW'(i + 1);
    end
    return r;
  endfunction

  function automatic logic signed [2:0] sat_step(input logic signed [2:0] t,
                                                 input logic up, input logic dn);
    logic signed [2:0] r;
    r = t;
    if (up && !dn && t != 3'sd3)  r = t + 3'sd1;
    if (dn && !up && t != -3'sd3) r = t - 3'sd1;
    return r;
  endfunction

  function automatic logic [1:0] mode_next(input logic [1:0] m);
    logic [1:0] r;
    if (m == 2'(NUM_MODES - 1)) r = 2'd0;
    else                        r = m + 2'd1;
    return r;
  endfunction

  // Debounce: count consecutive disagreeing frames, flip on reaching the limit
  always_comb begin
    deb_d = deb_q;
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (sample_valid) begin
        if (sensor_in[c] == deb_q[c]) begin
          cnt_d[c] = 4'd0;
        end else if (cnt_q[c] + 4'd1 == DEB_LIM) begin
          deb_d[c] = ~deb_q[c];
          cnt_d[c] = 4'd0;
        end else begin
          cnt_d[c] = cnt_q[c] + 4'd1;
        end
      end
    end
  end

  assign rise      = deb_q & ~deb_prev_q;
  assign notes     = deb_q[NUM_KEYS-1:0];
  assign note_rise = rise[NUM_KEYS-1:0];
  assign func_rise = rise[NCH-1:NUM_KEYS];

  always_comb begin
    last_held = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (last_key_q == TW'(i)) last_held = notes[i];
    end
  end

  // Winner selection; last_key is only tracked in most-recent mode
  always_comb begin
    last_key_d = last_key_q;
    if (PRIO_RECENT == 0) begin
      tone_d = lowest_tone(notes);
    end else begin
      if (|note_rise)
        last_key_d = lowest_tone(note_rise) - TW'(1);
      else if (!last_held && |notes)
        last_key_d = lowest_tone(notes) - TW'(1);
      tone_d = (|notes) ? last_key_d + TW'(1) : '0;
    end
  end

  // Transpose sees the mode in force before any same-cycle mode pulse
  always_comb begin
    mode_d = func_rise[2] ? mode_next(mode_q) : mode_q;
    tr_d   = (mode_q == 2'd0) ? sat_step(tr_q, func_rise[1], func_rise[0]) : tr_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= 4'd0;
      last_key_q <= '0;
      tone_q     <= '0;
      tone_en_q  <= 1'b0;
      func_q     <= '0;
      mode_q     <= 2'd0;
      tr_q       <= 3'sd0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= cnt_d[c];
      last_key_q <= last_key_d;
      tone_q     <= tone_d;
      tone_en_q  <= (tone_d != '0);
      func_q     <= func_rise;
      mode_q     <= mode_d;
      tr_q       <= tr_d;
    end
  end

  assign key_state  = notes;
  assign tone_idx   = tone_q;
  assign tone_en    = tone_en_q;
  assign func_pulse = func_q;
  assign mode       = mode_q;
  assign transpose  = tr_q;

endmodule

// File: tb/tb_touch_key_ctrl.sv
// Scoreboard bench: a cycle model pushes expected outputs as each cycle is
// driven; they are popped and compared after the clock edge.
module tb_touch_key_ctrl;
  localparam int NK  = 13;
  localparam int DEB = 3;
  localparam int NM  = 2;
  localparam logic [15:0] KD = 16'h2000;
  localparam logic [15:0] KU = 16'h4000;
  localparam logic [15:0] KM = 16'h8000;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] sensor_in;
  logic        sample_valid;
  logic [3:0]  tone_a, tone_b;
  logic        en_a, en_b;
  logic [12:0] ks_a, ks_b;
  logic [2:0]  fp_a, fp_b;
  logic [1:0]  md_a, md_b;
  logic [2:0]  tr_a, tr_b;

  touch_key_ctrl #(.NUM_KEYS(NK), .NUM_FUNC(3), .DEB_SAMPLES(DEB), .NUM_MODES(NM),
                   .PRIO_RECENT(0)) dut_low (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sensor_in(sensor_in),
    .sample_valid(sample_valid), .tone_idx(tone_a), .tone_en(en_a),
    .key_state(ks_a), .func_pulse(fp_a), .mode(md_a), .transpose(tr_a));

  touch_key_ctrl #(.NUM_KEYS(NK), .NUM_FUNC(3), .DEB_SAMPLES(DEB), .NUM_MODES(NM),
                   .PRIO_RECENT(1)) dut_rec (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sensor_in(sensor_in),
    .sample_valid(sample_valid), .tone_idx(tone_b), .tone_en(en_b),
    .key_state(ks_b), .func_pulse(fp_b), .mode(md_b), .transpose(tr_b));

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [12:0] ks;
    logic [3:0]  t0;
    logic        e0;
    logic [3:0]  t1;
    logic        e1;
    logic [2:0]  fp;
    logic [1:0]  md;
    logic [2:0]  tr;
  } exp_t;

  exp_t sb_q[$];

  logic [15:0]       m_deb, m_prev;
  int                m_cnt [16];
  int                m_last;
  logic [3:0]        m_t0, m_t1;
  logic [2:0]        m_fp;
  logic [1:0]        m_mode;
  logic signed [2:0] m_tr;

  function automatic int lowest(input logic [12:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_deb = '0; m_prev = '0; m_last = 0;
    m_t0 = '0; m_t1 = '0; m_fp = '0; m_mode = '0; m_tr = '0;
    for (int c = 0; c < 16; c++) m_cnt[c] = 0;
    sb_q.delete();
  endtask

  task automatic model_edge(input logic [15:0] raw, input logic sv);
    logic [15:0] rise;
    int lo, lr;
    rise = m_deb & ~m_prev;
    lo   = lowest(m_deb[12:0]);
    lr   = lowest(rise[12:0]);
    m_t0 = (lo < 0) ? 4'd0 : 4'(lo + 1);
    if (lr >= 0) m_last = lr;
    else if (!m_deb[m_last] && lo >= 0) m_last = lo;
    m_t1 = (lo < 0) ? 4'd0 : 4'(m_last + 1);
    m_fp = rise[15:13];
    if (m_mode == 2'd0 && rise[14] != rise[13]) begin
      if (rise[14] && m_tr != 3'sd3)  m_tr = m_tr + 3'sd1;
      if (rise[13] && m_tr != -3'sd3) m_tr = m_tr - 3'sd1;
    end
    if (rise[15]) m_mode = (int'(m_mode) == NM - 1) ? 2'd0 : m_mode + 2'd1;
    m_prev = m_deb;
    if (sv) begin
      for (int c = 0; c < 16; c++) begin
        if (raw[c] == m_deb[c]) m_cnt[c] = 0;
        else begin
          m_cnt[c]++;
          if (m_cnt[c] == DEB) begin
            m_deb[c] = ~m_deb[c];
            m_cnt[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic [15:0] raw, input logic sv);
    exp_t e;
    @(negedge clk_in);
    sensor_in    = raw;
    sample_valid = sv;
    model_edge(raw, sv);
    e.ks = m_deb[12:0]; e.t0 = m_t0; e.e0 = (m_t0 != 0); e.t1 = m_t1; e.e1 = (m_t1 != 0);
    e.fp = m_fp; e.md = m_mode; e.tr = m_tr;
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    e = sb_q.pop_front();
    check_val("sb_key_state_low", 32'(ks_a), 32'(e.ks));
    check_val("sb_key_state_rec", 32'(ks_b), 32'(e.ks));
    check_val("sb_tone_low", 32'(tone_a), 32'(e.t0));
    check_val("sb_en_low", 32'(en_a), 32'(e.e0));
    check_val("sb_tone_rec", 32'(tone_b), 32'(e.t1));
    check_val("sb_en_rec", 32'(en_b), 32'(e.e1));
    check_val("sb_func_pulse", 32'(fp_a), 32'(e.fp));
    check_val("sb_mode", 32'(md_a), 32'(e.md));
    check_val("sb_transpose", 32'(tr_a), 32'(e.tr));
  endtask

  task automatic strobe(input logic [15:0] raw);
    cycle(raw, 1'b1);
    cycle(raw, 1'b0);
  endtask

  task automatic frames(input logic [15:0] raw, input int n);
    for (int k = 0; k < n; k++) strobe(raw);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ks"}, 32'(ks_a), 32'd0);
    check_val({tag, "_tone"}, 32'(tone_a), 32'd0);
    check_val({tag, "_en"}, 32'(en_a), 32'd0);
    check_val({tag, "_tone_rec"}, 32'(tone_b), 32'd0);
    check_val({tag, "_fp"}, 32'(fp_a), 32'd0);
    check_val({tag, "_mode"}, 32'(md_a), 32'd0);
    check_val({tag, "_tr"}, 32'(tr_a), 32'd0);
  endtask

  initial begin
    int exp_tr [4];
    int pulses;
    logic [15:0] raw_cur;
    logic [15:0] flip;
    logic [3:0]  pat;
    exp_tr = '{1, 2, 3, 3};

    rst_n_in = 1'b0; sensor_in = '0; sample_valid = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset_init");
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // single note press and E+1 output latency
    strobe(16'h0008); strobe(16'h0008);
    check_val("deb_partial_ks", 32'(ks_a), 32'd0);
    cycle(16'h0008, 1'b1);
    check_val("deb_third_ks", 32'(ks_a), 32'h8);
    check_val("deb_third_tone_not_yet", 32'(tone_a), 32'd0);
    cycle(16'h0008, 1'b0);
    check_val("press3_tone", 32'(tone_a), 32'd4);
    check_val("press3_en", 32'(en_a), 32'd1);
    frames(16'h0000, 3);
    check_val("release3_en", 32'(en_a), 32'd0);

    // glitch pattern 1,1,0,1,1 never registers
    pat = 4'b0;
    for (int k = 0; k < 5; k++) begin
      strobe((k == 2) ? 16'h0000 : 16'h0008);
      check_val("glitch_ks", 32'(ks_a), 32'd0);
      check_val("glitch_en", 32'(en_a), 32'd0);
    end
    frames(16'h0000, 3);

    // priority modes
    frames(16'h0020, 3);
    check_val("prio_b5_low", 32'(tone_a), 32'd6);
    check_val("prio_b5_rec", 32'(tone_b), 32'd6);
    frames(16'h0024, 3);
    check_val("prio_b2_low", 32'(tone_a), 32'd3);
    check_val("prio_b2_rec", 32'(tone_b), 32'd3);
    frames(16'h0020, 3);
    check_val("prio_rel2_low", 32'(tone_a), 32'd6);
    check_val("prio_rel2_rec", 32'(tone_b), 32'd6);
    frames(16'h0000, 3);
    frames(16'h0004, 3);
    frames(16'h0024, 3);
    check_val("prio_recent_low", 32'(tone_a), 32'd3);
    check_val("prio_recent_rec", 32'(tone_b), 32'd6);
    frames(16'h0224, 3);
    check_val("prio_b9_rec", 32'(tone_b), 32'd10);
    frames(16'h0024, 3);
    check_val("prio_fallback_rec", 32'(tone_b), 32'd3);
    frames(16'h0000, 3);
    check_val("prio_none_rec", 32'(tone_b), 32'd0);

    // transpose saturation and single-cycle pulses
    for (int i = 0; i < 4; i++) begin
      frames(KU, 3);
      check_val("up_transpose", 32'(tr_a), 32'(exp_tr[i]));
      check_val("up_pulse", 32'(fp_a), 32'b010);
      cycle(KU, 1'b0);
      check_val("up_pulse_end", 32'(fp_a), 32'b000);
      frames(16'h0000, 3);
    end
    frames(KM, 3);
    check_val("mode_to1", 32'(md_a), 32'd1);
    frames(16'h0000, 3);
    frames(KU, 3);
    check_val("mode1_up_hold", 32'(tr_a), 32'd3);
    check_val("mode1_up_pulse", 32'(fp_a), 32'b010);
    cycle(KU, 1'b0);
    check_val("mode1_up_pulse_end", 32'(fp_a), 32'b000);
    frames(16'h0000, 3);
    frames(KD, 3);
    check_val("mode1_dn_hold", 32'(tr_a), 32'd3);
    frames(16'h0000, 3);
    frames(KM, 3);
    check_val("mode_wrap0", 32'(md_a), 32'd0);
    frames(16'h0000, 3);
    frames(KD, 3);
    check_val("dn_transpose", 32'(tr_a), 32'd2);
    frames(16'h0000, 3);
    frames(KU | KD, 3);
    check_val("updn_cancel", 32'(tr_a), 32'd2);
    check_val("updn_pulse", 32'(fp_a), 32'b011);
    frames(16'h0000, 3);
    frames(16'h0080, 3);
    frames(16'h0080 | KM | KU, 3);
    check_val("combo_mode", 32'(md_a), 32'd1);
    check_val("combo_tr_premode", 32'(tr_a), 32'd3);
    check_val("combo_pulse", 32'(fp_a), 32'b110);
    check_val("combo_note_kept", 32'(tone_a), 32'd8);
    frames(16'h0000, 3);

    // mode wraps back after NUM_MODES presses; a long hold pulses once
    for (int k = 0; k < NM; k++) begin
      frames(KM, 3);
      frames(16'h0000, 3);
    end
    check_val("mode_full_wrap", 32'(md_a), 32'd1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(KM, 1'b1);
      if (fp_a[2]) pulses++;
      cycle(KM, 1'b0);
      if (fp_a[2]) pulses++;
    end
    check_val("mode_hold_pulses", 32'(pulses), 32'd1);
    check_val("mode_hold_mode", 32'(md_a), 32'd0);
    frames(16'h0000, 3);

    // random frames against the model
    raw_cur = '0;
    for (int k = 0; k < 400; k++) begin
      flip = '0;
      if ($urandom_range(0, 3) == 0) flip[$urandom_range(0, 15)] = 1'b1;
      raw_cur = raw_cur ^ flip;
      cycle(raw_cur, 1'($urandom_range(0, 1)));
    end
    frames(16'h0000, 4);
    frames(KU, 3);
    frames(16'h0000, 3);

    // reset mid-debounce discards partial count
    frames(16'h0000, 3);
    strobe(16'h0008); strobe(16'h0008);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_all_zero("reset_async");
    model_reset();
    @(negedge clk_in);
    sample_valid = 1'b1;
    @(posedge clk_in);
    #1;
    check_val("reset_hold_ks", 32'(ks_a), 32'd0);
    @(negedge clk_in);
    sample_valid = 1'b0;
    rst_n_in = 1'b1;
    strobe(16'h0008); strobe(16'h0008);
    check_val("post_reset_partial", 32'(ks_a), 32'd0);
    cycle(16'h0008, 1'b1);
    check_val("post_reset_ks", 32'(ks_a), 32'h8);
    cycle(16'h0008, 1'b0);
    check_val("post_reset_tone", 32'(tone_a), 32'd4);
    frames(16'h0000, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
